// File: rtl/mult_share_arbiter.sv
// Shares one 20x8 unsigned multiplier among NUM_REQ requesters: round-robin grant, 2-stage pipeline, ID-tagged results.
// Define MULT_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration with no rotation pointer.
module mult_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [20*NUM_REQ-1:0]   req_a,
   input  logic [8*NUM_REQ-1:0]    req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [27:0]             res_product,
   output logic [ID_W-1:0]         res_id
);

   logic [19:0]     a_arr [NUM_REQ];
   logic [7:0]      b_arr [NUM_REQ];

   logic            s1_valid_reg;
   logic [19:0]     s1_a_reg;
   logic [7:0]      s1_b_reg;
   logic [ID_W-1:0] s1_id_reg;

   logic            res_valid_reg;
   logic [27:0]     res_product_reg;
   logic [ID_W-1:0] res_id_reg;

   logic            s2_advance;
   logic            s1_advance;
   logic            can_accept;
   logic            transfer;

   logic            grant_found;
   logic [ID_W-1:0] grant_id;
   logic            found_lo;
   logic [ID_W-1:0] id_lo;
   logic [27:0]     product;

`ifndef MULT_ARB_FIXED_PRIORITY_EN
   logic [ID_W-1:0] rr_ptr_reg;
   logic            found_hi;
   logic [ID_W-1:0] id_hi;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign a_arr[gi]     = req_a[20*gi +: 20];
         assign b_arr[gi]     = req_b[8*gi +: 8];
         assign req_ready[gi] = transfer && (grant_id == ID_W'(gi));
      end
   endgenerate

   assign s2_advance = !res_valid_reg || res_ready;
   assign s1_advance = s1_valid_reg && s2_advance;
   assign can_accept = !s1_valid_reg || s2_advance;
   assign transfer   = grant_found && can_accept && !reset;

   // Descending scan leaves the lowest matching index; the "hi" search covers indices after rr_ptr.
   always_comb begin
      found_lo = 1'b0;
      id_lo    = '0;
`ifndef MULT_ARB_FIXED_PRIORITY_EN
      found_hi = 1'b0;
      id_hi    = '0;
`endif
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            found_lo = 1'b1;
            id_lo    = ID_W'(i);
`ifndef MULT_ARB_FIXED_PRIORITY_EN
            if (ID_W'(i) > rr_ptr_reg) begin
               found_hi = 1'b1;
               id_hi    = ID_W'(i);
            end
`endif
         end
      end
      grant_found = found_lo;
`ifdef MULT_ARB_FIXED_PRIORITY_EN
      grant_id    = id_lo;
`else
      grant_id    = found_hi ? id_hi : id_lo;
`endif
   end

   assign product = {8'd0, s1_a_reg} * {20'd0, s1_b_reg};

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_reg    <= 1'b0;
         s1_a_reg        <= '0;
         s1_b_reg        <= '0;
         s1_id_reg       <= '0;
         res_valid_reg   <= 1'b0;
         res_product_reg <= '0;
         res_id_reg      <= '0;
`ifndef MULT_ARB_FIXED_PRIORITY_EN
         rr_ptr_reg      <= ID_W'(NUM_REQ - 1);
`endif
      end else begin
         if (transfer) begin
            s1_valid_reg <= 1'b1;
            s1_a_reg     <= a_arr[grant_id];
            s1_b_reg     <= b_arr[grant_id];
            s1_id_reg    <= grant_id;
`ifndef MULT_ARB_FIXED_PRIORITY_EN
            rr_ptr_reg   <= grant_id;
`endif
         end else if (s1_advance) begin
            s1_valid_reg <= 1'b0;
         end

         if (s2_advance) begin
            res_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               res_product_reg <= product;
               res_id_reg      <= s1_id_reg;
            end
         end
      end
   end

   assign res_valid   = res_valid_reg;
   assign res_product = res_product_reg;
   assign res_id      = res_id_reg;

endmodule
